// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
//   Bundles the MUL macro-op handshake and the ALU operand/result buses.
//   slave  : the sequencer view (drives ALU operands, opcode, product, busy, done)
//   master : datapath + ALU view (drives start, operands, ALU result and Z flag)
//   CNT_W  : width of the repeat-count operand b_in (must be <= 24)
interface alu_mul_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [23:0]      a_in;
   logic [CNT_W-1:0] b_in;
   logic [23:0]      alu_a;
   logic [23:0]      alu_b;
   logic [3:0]       alu_oper;
   logic [23:0]      alu_c;
   logic             alu_z;
   logic [23:0]      product;
   logic             busy;
   logic             done;

   modport slave (
      input  start, a_in, b_in, alu_c, alu_z,
      output alu_a, alu_b, alu_oper, product, busy, done
   );

   modport master (
      output start, a_in, b_in, alu_c, alu_z,
      input  alu_a, alu_b, alu_oper, product, busy, done
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multiply controller that computes a 24-bit product by repeated addition
//   through an external combinational ALU. Loop exit is tested with SUB
//   (count - 0) and the Z flag; the count is stepped down with DECAC.
//   Ports:
//     clk     : clock, rising edge
//     rst_n   : asynchronous active-low reset
//     mul_if  : slave modport -- start/a_in/b_in/product/busy/done handshake
//               and alu_a/alu_b/alu_oper out, alu_c/alu_z in
module alu_mul_sequencer (
   input  logic                clk,
   input  logic                rst_n,
   alu_mul_sequencer_if.slave  mul_if
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_DEC   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_DECAC = 4'd10;

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic [23:0] r_mcand;
   logic [23:0] r_count;
   logic [23:0] r_acc;
   logic [23:0] r_product;
   logic [23:0] w_alu_a;
   logic [23:0] w_alu_b;
   logic [3:0]  w_oper;

   // Moore bus drive: opcode depends on state alone, operands on state plus
   // registered data, so nothing here follows the ALU's combinational result.
   always_comb begin
      w_alu_a = 24'd0;
      w_alu_b = 24'd0;
      w_oper  = OP_NOP;
      case (r_state)
         S_CHECK: begin
            w_alu_a = r_count;
            w_oper  = OP_SUB;
         end
         S_ADD: begin
            w_alu_a = r_acc;
            w_alu_b = r_mcand;
            w_oper  = OP_ADD;
         end
         S_DEC: begin
            w_alu_a = r_count;
            w_oper  = OP_DECAC;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (mul_if.start) w_next = S_CHECK;
         S_CHECK: w_next = mul_if.alu_z ? S_DONE : S_ADD;
         S_ADD:   w_next = S_DEC;
         S_DEC:   w_next = S_CHECK;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_mcand   <= 24'd0;
         r_count   <= 24'd0;
         r_acc     <= 24'd0;
         r_product <= 24'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (mul_if.start) begin
               r_mcand <= mul_if.a_in;
               r_count <= 24'(mul_if.b_in);
               r_acc   <= 24'd0;
            end
            S_ADD:   r_acc     <= mul_if.alu_c;
            S_DEC:   r_count   <= mul_if.alu_c;
            S_DONE:  r_product <= r_acc;
            default: ;
         endcase
      end
   end

   assign mul_if.alu_a    = w_alu_a;
   assign mul_if.alu_b    = w_alu_b;
   assign mul_if.alu_oper = w_oper;
   assign mul_if.product  = r_product;
   assign mul_if.busy     = (r_state != S_IDLE);
   assign mul_if.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

   logic clk;
   logic rst_n;
   int   ncmp;
   int   nfail;
   bit   bad_op;

   alu_mul_sequencer_if #(.CNT_W(8)) mul_if ();

   alu_mul_sequencer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mul_if (mul_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU model: ADD=1, SUB=2, DECAC=10 (A-1), NOP=0
   assign mul_if.alu_c = (mul_if.alu_oper == 4'd1)  ? mul_if.alu_a + mul_if.alu_b :
                         (mul_if.alu_oper == 4'd2)  ? mul_if.alu_a - mul_if.alu_b :
                         (mul_if.alu_oper == 4'd10) ? mul_if.alu_a - 24'd1 : 24'd0;
   assign mul_if.alu_z = (mul_if.alu_oper == 4'd2) && (mul_if.alu_a == mul_if.alu_b);

   // Bus monitor: opcode must stay within the legal set
   always @(negedge clk) begin
      if (!(mul_if.alu_oper inside {4'd0, 4'd1, 4'd2, 4'd10})) bad_op = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One MUL op: accept at E0, track cycles k=0.. (cycle k follows edge E0+k).
   // inj >= 0 pulses a competing start (a=9,b=9) in cycle inj.
   task automatic run_op(input string tag, input logic [23:0] a, input logic [7:0] b,
                         input logic [23:0] exp, input int inj, output int adds);
      int  n;
      int  done_cyc;
      bit  seq_ok;
      logic [3:0] eop;
      n        = int'(b);
      done_cyc = -1;
      seq_ok   = 1'b1;
      adds     = 0;
      @(negedge clk);
      mul_if.a_in  = a;
      mul_if.b_in  = b;
      mul_if.start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 3*n + 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            mul_if.start = 1'b0;
            mul_if.a_in  = 24'hFFFFFF;
            mul_if.b_in  = 8'hFF;
         end
         if (k == inj) begin
            mul_if.start = 1'b1;
            mul_if.a_in  = 24'd9;
            mul_if.b_in  = 8'd9;
         end
         if (inj >= 0 && k == inj + 1) mul_if.start = 1'b0;
         if (mul_if.alu_oper == 4'd1) adds++;
         if (k <= 3*n) eop = (k % 3 == 0) ? 4'd2 : (k % 3 == 1) ? 4'd1 : 4'd10;
         else          eop = 4'd0;
         if (mul_if.alu_oper !== eop || mul_if.busy !== 1'b1) seq_ok = 1'b0;
         if (mul_if.done === 1'b1) begin
            done_cyc = k;
            break;
         end
      end
      chk({tag, "_done_cycle"}, done_cyc, 3*n + 1);
      chk({tag, "_op_seq"}, {31'd0, seq_ok}, 32'd1);
      @(negedge clk);
      chk({tag, "_product"}, {8'd0, mul_if.product}, {8'd0, exp});
      chk({tag, "_busy_after"}, {31'd0, mul_if.busy}, 32'd0);
   endtask

   initial begin
      int adds;
      int dcnt;
      int dcyc [3];
      bit prod_ok;
      ncmp   = 0;
      nfail  = 0;
      bad_op = 1'b0;
      rst_n  = 1'b0;
      mul_if.start = 1'b0;
      mul_if.a_in  = 24'd0;
      mul_if.b_in  = 8'd0;
      repeat (2) @(negedge clk);

      chk("rst_product", {8'd0, mul_if.product}, 32'd0);
      chk("rst_busy", {31'd0, mul_if.busy}, 32'd0);
      chk("rst_done", {31'd0, mul_if.done}, 32'd0);
      chk("rst_oper", {28'd0, mul_if.alu_oper}, 32'd0);
      chk("rst_alu_a", {8'd0, mul_if.alu_a}, 32'd0);
      chk("rst_alu_b", {8'd0, mul_if.alu_b}, 32'd0);
      rst_n = 1'b1;

      run_op("basic", 24'd7, 8'd5, 24'h000023, -1, adds);
      chk("basic_adds", adds, 5);
      run_op("zero", 24'hABCDEF, 8'd0, 24'h000000, -1, adds);
      chk("zero_adds", adds, 0);
      run_op("wrap1", 24'h123456, 8'd3, 24'h369D02, -1, adds);
      run_op("wrap2", 24'h100000, 8'd16, 24'h000000, -1, adds);
      run_op("busy_ign", 24'd2, 8'd4, 24'd8, 5, adds);
      run_op("fresh", 24'd9, 8'd9, 24'd81, -1, adds);

      // Back-to-back with start held high: done at cycles 7, 16, 25
      dcnt    = 0;
      prod_ok = 1'b1;
      @(negedge clk);
      mul_if.a_in  = 24'd3;
      mul_if.b_in  = 8'd2;
      mul_if.start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 26; k++) begin
         @(negedge clk);
         if (dcnt > 0 && k == dcyc[dcnt-1] + 1 && mul_if.product !== 24'd6) prod_ok = 1'b0;
         if (mul_if.done === 1'b1 && dcnt < 3) begin
            dcyc[dcnt] = k;
            dcnt++;
         end
      end
      mul_if.start = 1'b0;
      chk("b2b_count", dcnt, 3);
      chk("b2b_done0", dcyc[0], 7);
      chk("b2b_done1", dcyc[1], 16);
      chk("b2b_done2", dcyc[2], 25);
      chk("b2b_product", {31'd0, prod_ok}, 32'd1);
      repeat (3) @(negedge clk);
      chk("b2b_idle", {31'd0, mul_if.busy}, 32'd0);

      // Reset mid-operation
      mul_if.a_in  = 24'd7;
      mul_if.b_in  = 8'd200;
      mul_if.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mul_if.start = 1'b0;
      repeat (50) @(negedge clk);
      chk("midop_busy", {31'd0, mul_if.busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, mul_if.busy}, 32'd0);
      chk("midrst_done", {31'd0, mul_if.done}, 32'd0);
      chk("midrst_oper", {28'd0, mul_if.alu_oper}, 32'd0);
      chk("midrst_product", {8'd0, mul_if.product}, 32'd0);
      chk("midrst_alu_a", {8'd0, mul_if.alu_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_busy", {31'd0, mul_if.busy}, 32'd0);
      chk("post_rst_oper", {28'd0, mul_if.alu_oper}, 32'd0);
      run_op("recover", 24'd7, 8'd5, 24'h000023, -1, adds);

      chk("oper_legal", {31'd0, bad_op}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
